// File: rtl/pattern_shift_controller.sv
// rtl/pattern_shift_controller.sv - serial pattern trigger: shift_ena burst, count wait, ack re-arm
// Optional COUNT timeout enabled by defining SEQDET_TIMEOUT_EN.
module pattern_shift_controller #(
    parameter int               PAT_W        = 4,
    parameter logic [PAT_W-1:0] PATTERN      = 4'b1101,
    parameter int               SHIFT_CYCLES = 4,
    parameter int               TIMEOUT      = 256
) (
    input  logic clk,
    input  logic reset,
    input  logic data,
    input  logic done_counting,
    input  logic ack,
    output logic shift_ena,
    output logic counting,
    output logic done,
    output logic timeout_err
);

    localparam int FILL_W = $clog2(PAT_W);
    localparam int SH_W   = $clog2(SHIFT_CYCLES + 1);

    if (PAT_W < 2 || PAT_W > 32 || SHIFT_CYCLES < 1 || TIMEOUT < 1) begin : g_bad_params
        $error("pattern_shift_controller: illegal parameter value");
    end

    typedef enum logic [1:0] {
        S_SEARCH,
        S_SHIFT,
        S_COUNT,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [PAT_W-2:0]  hist_q, hist_d;
    logic [FILL_W-1:0] fill_q, fill_d;
    logic [SH_W-1:0]   sh_cnt_q, sh_cnt_d;
    logic [PAT_W-1:0]  window;

`ifdef SEQDET_TIMEOUT_EN
    localparam int TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic            terr_q, terr_d;
`endif

    assign window = {hist_q, data};

    always_comb begin
        state_d  = state_q;
        // History stays zero outside SEARCH, so every entry to SEARCH starts clean.
        hist_d   = '0;
        fill_d   = '0;
        sh_cnt_d = sh_cnt_q;
`ifdef SEQDET_TIMEOUT_EN
        to_cnt_d = '0;
        terr_d   = terr_q;
`endif
        case (state_q)
            S_SEARCH: begin
                hist_d = window[PAT_W-2:0];
                fill_d = fill_q;
                if (fill_q != FILL_W'(PAT_W - 1)) begin
                    fill_d = fill_q + FILL_W'(1);
                end
                if (fill_q == FILL_W'(PAT_W - 1) && window == PATTERN) begin
                    state_d  = S_SHIFT;
                    sh_cnt_d = '0;
                end
            end
            S_SHIFT: begin
                if (sh_cnt_q == SH_W'(SHIFT_CYCLES - 1)) begin
                    state_d = S_COUNT;
                end else begin
                    sh_cnt_d = sh_cnt_q + SH_W'(1);
                end
            end
            S_COUNT: begin
                if (done_counting) begin
                    state_d = S_DONE;
                end
`ifdef SEQDET_TIMEOUT_EN
                else if (to_cnt_q == TO_W'(TIMEOUT - 1)) begin
                    state_d = S_DONE;
                    terr_d  = 1'b1;
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end
`endif
            end
            S_DONE: begin
                if (ack) begin
                    state_d = S_SEARCH;
`ifdef SEQDET_TIMEOUT_EN
                    terr_d  = 1'b0;
`endif
                end
            end
            default: state_d = S_SEARCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_SEARCH;
            hist_q   <= '0;
            fill_q   <= '0;
            sh_cnt_q <= '0;
`ifdef SEQDET_TIMEOUT_EN
            to_cnt_q <= '0;
            terr_q   <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            hist_q   <= hist_d;
            fill_q   <= fill_d;
            sh_cnt_q <= sh_cnt_d;
`ifdef SEQDET_TIMEOUT_EN
            to_cnt_q <= to_cnt_d;
            terr_q   <= terr_d;
`endif
        end
    end

    assign shift_ena = (state_q == S_SHIFT);
    assign counting  = (state_q == S_COUNT);
    assign done      = (state_q == S_DONE);
`ifdef SEQDET_TIMEOUT_EN
    assign timeout_err = terr_q;
`else
    assign timeout_err = 1'b0;
`endif

endmodule

// File: doc/pattern_shift_controller.md
# pattern_shift_controller

Parametrised serial-pattern trigger controller for the bit-serial timer path. It scans a 1-bit input stream for a configurable PAT_W-bit pattern, with overlapping matches allowed. On a match it asserts shift_ena for exactly SHIFT_CYCLES cycles, then waits for the downstream counter to finish and for the user to acknowledge. It then re-arms on its own, which the earlier sticky one-shot detectors did not do.

## Interface
- PAT_W, 4, pattern length in bits; legal range 2..32
- PATTERN, 4'b1101, match value; MSB is the oldest bit received
- SHIFT_CYCLES, 4, length of the shift_ena burst; must be ≥1
- TIMEOUT, 256, maximum COUNT dwell in cycles; must be ≥1; used only when SEQDET_TIMEOUT_EN is defined
- clk  input  1  clock, all logic on posedge
- reset  input  1  reset, synchronous, active-high
- data  input  1  serial bit stream, one bit per cycle
- done_counting  input  1  downstream counter finished
- ack  input  1  user acknowledge of done
- shift_ena  output  1  load-shift enable burst
- counting  output  1  waiting for done_counting
- done  output  1  transaction complete, held until ack
- timeout_err  output  1  COUNT exited by timeout, held until ack

## Operation
- States: SEARCH, SHIFT, COUNT, DONE.
- All outputs are Moore outputs decoded from registered state and flags; there are no combinational input-to-output paths.
- Reset forces SEARCH, clears the history and fill counter, and drives all outputs to 0. Reset has priority in every state, including mid-burst.
- SEARCH behaviour:
  - Each cycle, hist <= {hist[PAT_W-2:0], data}.
  - fill counts bits received since entering SEARCH and saturates at PAT_W-1.
  - Match condition: {hist[PAT_W-2:0], data} == PATTERN and fill == PAT_W-1.
  - hist and fill are cleared on reset and on every entry to SEARCH. This prevents false matches on stale or zero history.
  - Overlap is allowed: a failed partial match does not discard bits. Every cycle compares against the full window.
- Match in SEARCH → SHIFT. The shift counter (width $clog2(SHIFT_CYCLES+1)) loads 0.
- SHIFT behaviour:
  - shift_ena=1 in every SHIFT cycle.
  - When the counter reaches SHIFT_CYCLES-1, go to COUNT; otherwise increment.
  - done_counting and ack are ignored.
- COUNT behaviour:
  - counting=1.
  - done_counting=1 → DONE.
  - ack is ignored.
- DONE behaviour:
  - done=1.
  - ack=1 → SEARCH; hist and fill are cleared.
  - data sampled in DONE is discarded.
- Boundary conditions:
  - done_counting already high on the first COUNT cycle → COUNT lasts exactly 1 cycle.
  - ack held high continuously → DONE lasts exactly 1 cycle.

## Timing
- Let the last pattern bit be sampled at edge t.
  - shift_ena is high in cycles t+1 .. t+SHIFT_CYCLES.
  - counting goes high at t+SHIFT_CYCLES+1.
- done_counting sampled at edge u in COUNT → done=1 and counting=0 from cycle u+1.
- ack sampled at edge v in DONE → done=0 from v+1. The bit sampled at v+1 is the first bit of the new search.
- Minimum re-trigger distance after ack is PAT_W cycles.

## Configuration
- SEQDET_TIMEOUT_EN defined:
  - A timeout counter of width $clog2(TIMEOUT) is cleared on COUNT entry.
  - It increments on each COUNT cycle where done_counting=0.
  - If it equals TIMEOUT-1 and done_counting=0 → DONE with timeout_err=1. COUNT therefore lasts at most TIMEOUT cycles.
  - If done_counting=1 in the same cycle as expiry, done_counting wins and timeout_err=0.
  - timeout_err clears with done on ack or on reset.
- SEQDET_TIMEOUT_EN undefined:
  - No timeout logic is built and TIMEOUT is ignored.
  - timeout_err is tied to 0.
  - COUNT waits indefinitely.

## Test plan
- Defaults, after reset, data 1,1,0,1 → shift_ena=1 for exactly the 4 cycles after the 4th bit. Then counting=1; shift_ena never re-asserts while data keeps toggling.
- Overlap: data 1,1,1,0,1 → a single match on the 5th bit, with shift_ena starting the next cycle.
- Pulse done_counting during SHIFT → ignored. Pulse in COUNT → done=1 next cycle, held 10 cycles until ack=1, then done=0. Data 1,0,1 immediately after ack → no match (history cleared).
- Reset asserted in the 2nd SHIFT cycle → next cycle shift_ena=counting=done=0 in SEARCH. A fresh 1,1,0,1 triggers normally.
- PAT_W=6, PATTERN=6'b001011, SHIFT_CYCLES=3:
  - After reset, data 1,0,1,1 → no match (fill protection).
  - Then data 0,0,1,0,1,1 → shift_ena high 3 cycles.
- SEQDET_TIMEOUT_EN, TIMEOUT=8, no done_counting → counting high 8 cycles, then done=timeout_err=1.
  - Same stimulus without the macro → counting still 1 after 100 cycles, timeout_err=0.
